// File: rtl/ram_wr_arb_pkg.sv
// Shared definitions for the BIO RAM write arbiter: default widths, the
// requester index type and the rotating-priority search helper.
// Optional build macro: RAM_WR_ARB_HOST_PRIO_EN (host has absolute priority).
package ram_wr_arb_pkg;

  localparam int NUM_REQ_DEF = 5;
  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 32;
  localparam int MASK_W_DEF  = 4;
  localparam int CNT_W_DEF   = 16;

  // The host bus is always the highest requester index.
  localparam int HOST_IDX = NUM_REQ_DEF - 1;

  // Upper bound on requesters the search helper can scan.
  localparam int RR_MAX = 32;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;

  // Rotating priority search: scan ptr, ptr+1, ... modulo n and return the
  // first index whose valid bit is set, or -1 when nobody is requesting.
  function automatic int rr_search(input logic [RR_MAX-1:0] valid,
                                   input int unsigned n,
                                   input int unsigned ptr);
    int          sel;
    int unsigned j;
    sel = -1;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      if (i < n) begin
        j = ptr + i;
        if (j >= n) begin
          j = j - n;
        end else begin
          j = j;
        end
        if ((sel < 0) && valid[j[4:0]]) begin
          sel = int'(j);
        end else begin
          sel = sel;
        end
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ram_wr_arb_if.sv
// Requester-side handshake bundle plus the registered RAM write port.
// slave = the arbiter, master = requesters / RAM side.
interface ram_wr_arb_if
  import ram_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MASK_W  = MASK_W_DEF
) ();

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*MASK_W-1:0] req_mask;

  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [MASK_W-1:0]         wr_mask;
  logic [IW-1:0]             wr_id;

  modport slave (
    input  req_valid, req_addr, req_data, req_mask,
    output req_ready, wr_en, wr_addr, wr_data, wr_mask, wr_id
  );

  modport master (
    output req_valid, req_addr, req_data, req_mask,
    input  req_ready, wr_en, wr_addr, wr_data, wr_mask, wr_id
  );

endinterface

// File: rtl/ram_wr_arb_rr.sv
// Round-robin grant for N requesters: combinational one-hot grant plus a
// registered rotation pointer. Under RAM_WR_ARB_HOST_PRIO_EN the top index
// (host) wins outright and the remaining N-1 cores rotate among themselves;
// host grants leave the pointer alone.
module rr_arbiter
  import ram_wr_arb_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  i_valid,
  output logic [N-1:0]  o_gnt,
  output logic          o_gnt_vld,
  output logic [IW-1:0] o_gnt_idx
);

`ifdef RAM_WR_ARB_HOST_PRIO_EN
  localparam int RRN = N - 1;
`else
  localparam int RRN = N;
`endif

  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     w_ptr_nxt;
  logic [RR_MAX-1:0] w_vec;
  logic              w_host;
  int                w_sel;

  // Pick the winner; nothing is granted while reset is high
  always_comb begin
    w_vec          = '0;
    w_vec[N-1:0]   = i_valid;
`ifdef RAM_WR_ARB_HOST_PRIO_EN
    w_host         = i_valid[N-1];
    w_vec[N-1]     = 1'b0;
`else
    w_host         = 1'b0;
`endif
    w_sel          = rr_search(w_vec, RRN, int'(r_ptr));
    o_gnt          = '0;
    o_gnt_vld      = 1'b0;
    o_gnt_idx      = '0;
    if (reset) begin
      o_gnt_vld    = 1'b0;
    end else if (w_host) begin
      o_gnt[N-1]   = 1'b1;
      o_gnt_vld    = 1'b1;
      o_gnt_idx    = IW'(N - 1);
    end else if (w_sel >= 0) begin
      o_gnt_idx    = IW'(w_sel);
      o_gnt[o_gnt_idx] = 1'b1;
      o_gnt_vld    = 1'b1;
    end else begin
      o_gnt_vld    = 1'b0;
    end
  end

  // Next pointer is one past the granted core, wrapping within the ring
  always_comb begin
    if (o_gnt_idx == IW'(RRN - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = o_gnt_idx + IW'(1);
    end
  end

  // Advance the rotation only on a round-robin (non-host) grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (o_gnt_vld && !w_host) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/ram_wr_arb.sv
// Write arbiter in front of the shared 1W/4R BIO RAM. Grants one requester
// per cycle, registers the winning beat onto the RAM write port and keeps a
// saturating count of contended cycles. wr_addr doubles as the in-flight
// address for read-side collision detection.
// Optional build macro: RAM_WR_ARB_HOST_PRIO_EN (see rr_arbiter).
module ram_wr_arb
  import ram_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MASK_W  = MASK_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  ram_wr_arb_if.slave       bus,
  input  logic              contention_clr,
  output logic [CNT_W-1:0]  contention_cnt
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_gnt;
  logic               w_gnt_vld;
  logic [IW-1:0]      w_gnt_idx;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;
  logic [MASK_W-1:0]  w_mask;
  logic               w_multi;

  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic [MASK_W-1:0]  r_wr_mask;
  logic [IW-1:0]      r_wr_id;
  logic [CNT_W-1:0]   r_cnt;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (bus.req_valid),
    .o_gnt     (w_gnt),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx)
  );

  assign bus.req_ready = w_gnt;

  // Select the granted requester's payload
  always_comb begin
    w_addr = bus.req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
    w_data = bus.req_data[w_gnt_idx*DATA_W +: DATA_W];
    w_mask = bus.req_mask[w_gnt_idx*MASK_W +: MASK_W];
  end

  // Two or more valid bits: clearing the lowest set bit leaves something
  assign w_multi = |(bus.req_valid & (bus.req_valid - NUM_REQ'(1)));

  // Output beat register; payload holds on idle cycles to avoid toggling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_mask <= '0;
      r_wr_id   <= '0;
    end else begin
      r_wr_en <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
        r_wr_mask <= w_mask;
        r_wr_id   <= w_gnt_idx;
      end
    end
  end

  // Saturating contention counter; clear beats increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (contention_clr) begin
      r_cnt <= '0;
    end else if (w_multi && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.wr_mask    = r_wr_mask;
  assign bus.wr_id      = r_wr_id;
  assign contention_cnt = r_cnt;

endmodule
